// File: rtl/hc595_pkg.sv
// Shared types and constants for the 74HC595 display scan controller:
// FSM encoding, frame width and the hex-to-7-segment table.
package hc595_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_LATCH = 2'd3
  } state_t;

  localparam int FRAME_BITS = 16;

  // Active-high {g,f,e,d,c,b,a} patterns, indexed by nibble value
  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic [7:0] SEG_BLANK = 8'h00;

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational hex nibble to active-high segment byte {dp,g,f,e,d,c,b,a}.
module seg7_hex_decode
  import hc595_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       dp,
  output logic [7:0] seg
);

  assign seg = {dp, SEG_TABLE[nibble]};

endmodule

// File: rtl/hc595_scan_ctrl.sv
// Multiplexed 7-segment scan controller driving two daisy-chained 74HC595s.
// Optional leading-zero blanking is enabled by defining LEADING_ZERO_BLANK_EN.
//
// state    | meaning
// ST_IDLE  | waiting for scan_tick
// ST_LOAD  | sample digit inputs, build {seg, sel} frame
// ST_SHIFT | shift 16 bits MSB first on ser/sclk
// ST_LATCH | pulse rclk, then advance digit_idx
module hc595_scan_ctrl
  import hc595_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int SCLK_DIV       = 4,
  parameter int SEG_ACTIVE_LOW = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    scan_tick,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp,
  output logic                    ser,
  output logic                    sclk,
  output logic                    rclk,
  output logic                    busy,
  output logic [2:0]              digit_idx
);

  localparam int                DIV_W    = (SCLK_DIV > 1) ? $clog2(SCLK_DIV) : 1;
  localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(SCLK_DIV - 1);
  localparam int                BIT_W    = $clog2(FRAME_BITS);
  localparam logic [BIT_W-1:0]  BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [2:0]        IDX_LAST = 3'(NUM_DIGITS - 1);

  state_t                  state_q, state_d;
  logic [FRAME_BITS-1:0]   frame_q, frame_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic                    ser_q, ser_d;
  logic                    sclk_q, sclk_d;
  logic                    rclk_q, rclk_d;
  logic                    busy_q, busy_d;
  logic [2:0]              idx_q, idx_d;

  logic [3:0]              cur_nib;
  logic                    cur_dp;
  logic [7:0]              dec_seg;
  logic [7:0]              seg_ah;
  logic [7:0]              seg_out;
  logic [7:0]              sel;
  logic [FRAME_BITS-1:0]   frame_word;

`ifdef LEADING_ZERO_BLANK_EN
  logic [NUM_DIGITS-1:0]   blank_mask;
  logic                    zero_run;
  logic                    cur_blank;

  // A digit is blanked when it and every digit above it is zero; digit 0 always shows
  always_comb begin
    blank_mask = '0;
    zero_run   = 1'b1;
    for (int i = NUM_DIGITS - 1; i > 0; i--) begin
      zero_run      = zero_run & (digits[4*i +: 4] == 4'h0);
      blank_mask[i] = zero_run;
    end
  end
`endif

  always_comb begin
    cur_nib = 4'h0;
    cur_dp  = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    cur_blank = 1'b0;
`endif
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == 3'(i)) begin
        cur_nib = digits[4*i +: 4];
        cur_dp  = dp[i];
`ifdef LEADING_ZERO_BLANK_EN
        cur_blank = blank_mask[i];
`endif
      end
    end
  end

  seg7_hex_decode u_dec (
    .nibble (cur_nib),
    .dp     (cur_dp),
    .seg    (dec_seg)
  );

  always_comb begin
    seg_ah = dec_seg;
`ifdef LEADING_ZERO_BLANK_EN
    if (cur_blank) seg_ah = SEG_BLANK;
`endif
    seg_out    = (SEG_ACTIVE_LOW != 0) ? ~seg_ah : seg_ah;
    sel        = 8'h01 << idx_q;
    frame_word = {seg_out, sel};
  end

  always_comb begin
    state_d = state_q;
    frame_d = frame_q;
    div_d   = div_q;
    bit_d   = bit_q;
    ser_d   = ser_q;
    sclk_d  = sclk_q;
    rclk_d  = rclk_q;
    busy_d  = busy_q;
    idx_d   = idx_q;
    case (state_q)
      ST_IDLE: begin
        if (scan_tick) begin
          state_d = ST_LOAD;
          busy_d  = 1'b1;
        end
      end
      ST_LOAD: begin
        frame_d = frame_word;
        ser_d   = frame_word[FRAME_BITS-1];
        sclk_d  = 1'b0;
        div_d   = DIV_LOAD;
        bit_d   = BIT_LAST;
        state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else if (!sclk_q) begin
          sclk_d = 1'b1;
          div_d  = DIV_LOAD;
        end else if (bit_q == '0) begin
          sclk_d  = 1'b0;
          rclk_d  = 1'b1;
          div_d   = DIV_LOAD;
          state_d = ST_LATCH;
        end else begin
          // Next bit goes out on the first cycle of its low phase
          sclk_d = 1'b0;
          bit_d  = bit_q - BIT_W'(1);
          ser_d  = frame_q[bit_q - BIT_W'(1)];
          div_d  = DIV_LOAD;
        end
      end
      ST_LATCH: begin
        if (div_q != '0) begin
          div_d = div_q - DIV_W'(1);
        end else begin
          rclk_d  = 1'b0;
          busy_d  = 1'b0;
          idx_d   = (idx_q == IDX_LAST) ? 3'd0 : idx_q + 3'd1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      frame_q <= '0;
      div_q   <= '0;
      bit_q   <= '0;
      ser_q   <= 1'b0;
      sclk_q  <= 1'b0;
      rclk_q  <= 1'b0;
      busy_q  <= 1'b0;
      idx_q   <= 3'd0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      ser_q   <= ser_d;
      sclk_q  <= sclk_d;
      rclk_q  <= rclk_d;
      busy_q  <= busy_d;
      idx_q   <= idx_d;
    end
  end

  assign ser       = ser_q;
  assign sclk      = sclk_q;
  assign rclk      = rclk_q;
  assign busy      = busy_q;
  assign digit_idx = idx_q;

endmodule

// File: tb/tb_hc595_scan_ctrl.sv
// Scoreboard bench for hc595_scan_ctrl: stimulus pushes expected frames,
// a monitor reassembles serial frames on each rclk pulse and compares.
module tb_hc595_scan_ctrl;

  localparam int ND = 8;
  localparam int D  = 4;
  localparam int T_RCLK = 2 + 32 * D;
  localparam int T_DONE = 2 + 33 * D;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          scan_tick = 1'b0;
  logic [31:0]   digits = '0;
  logic [7:0]    dp = '0;
  logic          ser, sclk, rclk, busy;
  logic [2:0]    digit_idx;

  int            n_chk = 0;
  int            n_fail = 0;
  logic [15:0]   exp_q[$];
  int            rclk_cnt = 0;
  int            m_idx = 0;

  logic [15:0]   shreg = '0;
  int            nbits = 0;
  logic          sclk_p = 1'b0;
  logic          rclk_p = 1'b0;

  logic [7:0]    hex_tab [16] = '{
    8'h3F, 8'h06, 8'h5B, 8'h4F, 8'h66, 8'h6D, 8'h7D, 8'h07,
    8'h7F, 8'h6F, 8'h77, 8'h7C, 8'h39, 8'h5E, 8'h79, 8'h71
  };

  hc595_scan_ctrl #(.NUM_DIGITS(ND), .SCLK_DIV(D), .SEG_ACTIVE_LOW(1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .scan_tick (scan_tick),
    .digits    (digits),
    .dp        (dp),
    .ser       (ser),
    .sclk      (sclk),
    .rclk      (rclk),
    .busy      (busy),
    .digit_idx (digit_idx)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] model(input logic [31:0] dg, input logic [7:0] dpv, input int idx);
    logic [7:0] seg;
    logic [3:0] nib;
    nib = 4'((dg >> (4 * idx)) & 32'hF);
    seg = hex_tab[nib] | (dpv[idx] ? 8'h80 : 8'h00);
`ifdef LEADING_ZERO_BLANK_EN
    if (idx > 0 && (dg >> (4 * idx)) == 32'd0) seg = 8'h00;
`endif
    return {~seg, 8'(1 << idx)};
  endfunction

  always @(negedge clk) begin
    if (!rst_n) begin
      nbits  = 0;
      sclk_p = 1'b0;
      rclk_p = 1'b0;
    end else begin
      if (sclk && !sclk_p) begin
        shreg = {shreg[14:0], ser};
        nbits++;
      end
      if (rclk && !rclk_p) begin
        rclk_cnt++;
        chk("frame_bit_count", nbits, 16);
        if (exp_q.size() == 0) begin
          n_chk++;
          n_fail++;
          $display("FAIL unexpected_frame: got %h expected no frame", shreg);
        end else begin
          chk("frame", shreg, exp_q.pop_front());
        end
        nbits = 0;
      end
      sclk_p = sclk;
      rclk_p = rclk;
    end
  end

  // One full scan: tick at cycle 0, optional second tick while busy,
  // optional input change mid-shift, then timing and index checks.
  task automatic do_frame(input logic [31:0] dg, input logic [7:0] dpv,
                          input bit chg, input int extra_tick, input int gap);
    int cyc;
    int cnt0;
    cnt0 = rclk_cnt;
    @(negedge clk);
    digits    = dg;
    dp        = dpv;
    scan_tick = 1'b1;
    exp_q.push_back(model(dg, dpv, m_idx));
    m_idx = (m_idx + 1) % ND;
    @(negedge clk);
    scan_tick = 1'b0;
    cyc = 1;
    chk("busy_at_load", busy, 1);
    while (!rclk && cyc < 400) begin
      if (chg && cyc == 10) begin
        digits = $urandom;
        dp     = 8'($urandom);
      end
      scan_tick = (extra_tick != 0 && cyc == extra_tick);
      @(negedge clk);
      cyc++;
    end
    scan_tick = 1'b0;
    chk("rclk_rise_cycle", cyc, T_RCLK);
    while (busy && cyc < 400) begin
      @(negedge clk);
      cyc++;
    end
    chk("busy_fall_cycle", cyc, T_DONE);
    chk("digit_idx", digit_idx, m_idx);
    chk("rclk_pulses", rclk_cnt, cnt0 + 1);
    repeat (gap) @(negedge clk);
  endtask

  initial begin
    int cyc;
    int cnt0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_ser", ser, 0);
    chk("rst_sclk", sclk, 0);
    chk("rst_rclk", rclk, 0);
    chk("rst_busy", busy, 0);
    chk("rst_idx", digit_idx, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Known frame: digit 0 = 5 -> seg 92, sel 01
    chk("model_5", model(32'h0000_0005, 8'h00, 0), 16'h9201);
    do_frame(32'h0000_0005, 8'h00, 1'b0, 0, 20);

    // Reset in the middle of SHIFT discards the frame
    cnt0 = rclk_cnt;
    @(negedge clk);
    digits    = 32'h1234_5678;
    scan_tick = 1'b1;
    @(negedge clk);
    scan_tick = 1'b0;
    cyc = 1;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    rst_n = 1'b0;
    #1;
    chk("midrst_ser", ser, 0);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_rclk", rclk, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_idx", digit_idx, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    m_idx = 0;
    repeat (150) @(negedge clk);
    chk("midrst_no_latch", rclk_cnt, cnt0);
    do_frame(32'h0000_00A7, 8'h01, 1'b0, 0, 10);

    // Tick while busy is ignored
    do_frame(32'hFEDC_BA98, 8'hFF, 1'b0, 50, 150);
    chk("ignored_tick_no_frame", rclk_cnt, cnt0 + 2);

    // Full sweep with wrap; inputs change mid-shift on some frames
    for (int k = 0; k < 12; k++)
      do_frame($urandom, 8'($urandom), k[0], 0, $urandom_range(5, 60));

    // Leading-zero patterns
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_idx = 0;
    for (int k = 0; k < ND; k++) do_frame(32'h0000_0120, 8'h00, 1'b0, 0, 5);
    for (int k = 0; k < ND; k++) do_frame(32'h0000_0000, 8'h80, 1'b0, 0, 5);

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
